// File: rtl/sprite_pkg.sv
// Shared sprite types and geometry defaults; SPRITE_SCALE2X_EN selects 2x on-screen scaling.
// No logic, no latency, no flow control.
package sprite_pkg;

    localparam int SPR_W_DEF = 16;
    localparam int SPR_H_DEF = 16;

`ifdef SPRITE_SCALE2X_EN
    localparam int SPR_S  = 2;
    localparam int SPR_SH = 1;
`else
    localparam int SPR_S  = 1;
    localparam int SPR_SH = 0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WAIT_X = 2'd2,
        SHIFT  = 2'd3
    } spr_state_t;

endpackage

// File: rtl/sprite_row_shifter.sv
// Sprite row load/shift register with emitted-bit counter; SPRITE_SCALE2X_EN adds a 2-strobe hold.
// Latency: load and step take effect on the next edge; no backpressure, driven by the sequencer FSM.
module sprite_row_shifter
    import sprite_pkg::*;
#(
    parameter int SPR_W = SPR_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [SPR_W-1:0] data_i,
    input  logic             step_i,
    output logic             bit_o,
    output logic             done_o
);

    localparam int CW = $clog2(SPR_W + 1);

    logic [SPR_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             adv;

`ifdef SPRITE_SCALE2X_EN
    logic hold_q, hold_d;

    // Each bit is presented for two strobes; the shift happens on the second one.
    always_comb begin
        hold_d = hold_q;
        if (load_i) begin
            hold_d = 1'b0;
        end else if (step_i) begin
            hold_d = ~hold_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign adv = step_i && hold_q;
`else
    assign adv = step_i;
`endif

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
        end else if (adv) begin
            shreg_d = {shreg_q[SPR_W-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_o  = shreg_q[SPR_W-1];
    assign done_o = (cnt_q == CW'(SPR_W));

endmodule

// File: rtl/sprite_line_sequencer.sv
// Per-scanline sprite ROM fetch and MSB-first pixel mask serialiser; SPRITE_SCALE2X_EN doubles size.
// Latency: pix_on lags its pix_en by one strobe; no backpressure, line_start aborts any line in flight.
module sprite_line_sequencer
    import sprite_pkg::*;
#(
    parameter int XW    = 10,
    parameter int YW    = 10,
    parameter int SPR_W = SPR_W_DEF,
    parameter int SPR_H = SPR_H_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     line_start,
    input  logic                     pix_en,
    input  logic [XW-1:0]            vga_x,
    input  logic [YW-1:0]            vga_y,
    input  logic                     spr_en,
    input  logic [XW-1:0]            spr_x,
    input  logic [YW-1:0]            spr_y,
    output logic [$clog2(SPR_H)-1:0] rom_addr,
    input  logic [SPR_W-1:0]         rom_data,
    output logic                     pix_on,
    output logic                     busy
);

    localparam int            AW   = $clog2(SPR_H);
    localparam logic [YW-1:0] SPAN = YW'(SPR_H * SPR_S);

    spr_state_t    state_q, state_d;
    logic [XW-1:0] latch_x_q, latch_x_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          pix_on_q, pix_on_d;

    logic [YW-1:0] dy;
    logic          hit;
    logic          x_match;
    logic          sh_load, sh_step, sh_bit, sh_done;

    // The explicit >= guard keeps a sprite near the bottom from wrapping onto the top lines.
    assign dy      = vga_y - spr_y;
    assign hit     = spr_en && (vga_y >= spr_y) && (dy < SPAN);
    assign x_match = (vga_x == latch_x_q);

    sprite_row_shifter #(
        .SPR_W (SPR_W)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (sh_load),
        .data_i (rom_data),
        .step_i (sh_step),
        .bit_o  (sh_bit),
        .done_o (sh_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = hit ? FETCH : IDLE;
        end else begin
            case (state_q)
                FETCH:   state_d = WAIT_X;
                WAIT_X:  if (pix_en && x_match) state_d = SHIFT;
                SHIFT:   if (pix_en && sh_done) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        latch_x_d  = latch_x_q;
        rom_addr_d = rom_addr_q;
        pix_on_d   = pix_on_q;
        sh_load    = 1'b0;
        sh_step    = 1'b0;
        if (line_start) begin
            latch_x_d = spr_x;
            pix_on_d  = 1'b0;
            if (hit) begin
                rom_addr_d = AW'(dy >> SPR_SH);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (pix_en) pix_on_d = 1'b0;
                end
                FETCH: begin
                    sh_load = 1'b1;
                end
                WAIT_X: begin
                    if (pix_en) begin
                        pix_on_d = x_match ? sh_bit : 1'b0;
                        sh_step  = x_match;
                    end
                end
                SHIFT: begin
                    if (pix_en) begin
                        pix_on_d = sh_done ? 1'b0 : sh_bit;
                        sh_step  = !sh_done;
                    end
                end
                default: pix_on_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_x_q  <= '0;
            rom_addr_q <= '0;
            pix_on_q   <= 1'b0;
        end else begin
            latch_x_q  <= latch_x_d;
            rom_addr_q <= rom_addr_d;
            pix_on_q   <= pix_on_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign pix_on   = pix_on_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_sequencer.sv
// Randomised and directed scanline bench for sprite_line_sequencer against a pixel-index reference model.
`timescale 1ns/1ps
module tb_sprite_line_sequencer;

    localparam int XW = 10;
    localparam int YW = 10;
    localparam int W  = 16;
    localparam int H  = 16;
`ifdef SPRITE_SCALE2X_EN
    localparam int S  = 2;
`else
    localparam int S  = 1;
`endif

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          line_start = 1'b0;
    logic          pix_en     = 1'b0;
    logic          spr_en     = 1'b0;
    logic [XW-1:0] vga_x      = '0;
    logic [XW-1:0] spr_x      = '0;
    logic [YW-1:0] vga_y      = '0;
    logic [YW-1:0] spr_y      = '0;
    logic [3:0]    rom_addr;
    logic [W-1:0]  rom_data;
    logic          pix_on;
    logic          busy;

    logic [W-1:0]  rom [H];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    sprite_line_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .pix_en     (pix_en),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_on     (pix_on),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: a line is a run of pixel indices k counted from the first pixel at latch_x.
    logic          m_armed, m_gap, m_pix;
    int            m_k;
    logic [W-1:0]  m_row;
    logic [XW-1:0] m_x;
    logic [3:0]    m_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_gap   = 1'b0;
        m_pix   = 1'b0;
        m_k     = -1;
        m_row   = '0;
        m_x     = '0;
        m_addr  = '0;
    endtask

    task automatic model_clock();
        int dy;
        if (line_start) begin
            dy    = int'(YW'(vga_y - spr_y));
            m_x   = spr_x;
            m_pix = 1'b0;
            m_k   = -1;
            if (spr_en && vga_y >= spr_y && dy < H * S) begin
                m_addr  = 4'(dy / S);
                m_row   = rom[m_addr];
                m_armed = 1'b1;
                m_gap   = 1'b1;
            end else begin
                m_armed = 1'b0;
                m_gap   = 1'b0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (pix_en) begin
            if (!m_armed) begin
                m_pix = 1'b0;
            end else if (m_k < 0) begin
                if (vga_x == m_x) begin
                    m_k   = 0;
                    m_pix = m_row[W-1];
                end else begin
                    m_pix = 1'b0;
                end
            end else begin
                m_k++;
                if (m_k < W * S) begin
                    m_pix = m_row[W-1-(m_k/S)];
                end else begin
                    m_pix   = 1'b0;
                    m_armed = 1'b0;
                end
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_pix_on"},   32'(pix_on),   32'(m_pix));
        chk({pfx, "_busy"},     32'(busy),     32'(m_armed | m_gap));
        chk({pfx, "_rom_addr"}, 32'(rom_addr), 32'(m_addr));
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic step(input logic ls, input logic pe, input logic [XW-1:0] x);
        line_start = ls;
        pix_en     = pe;
        vga_x      = x;
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_outputs("cyc");
        line_start = 1'b0;
        pix_en     = 1'b0;
    endtask

    task automatic start_line(input logic [YW-1:0] y);
        vga_y = y;
        step(1'b1, 1'($urandom), XW'($urandom));
        spr_x  = XW'($urandom);
        spr_y  = YW'($urandom);
        spr_en = 1'($urandom);
    endtask

    task automatic sweep(input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, XW'($urandom));
            step(1'b0, 1'b1, XW'(x));
        end
    endtask

    task automatic set_spr(input int sx, input int sy, input logic en);
        spr_x  = XW'(sx);
        spr_y  = YW'(sy);
        spr_en = en;
    endtask

    initial begin
        int x0;
        for (int i = 0; i < H; i++) rom[i] = W'($urandom);
        rom[2] = 16'hA5C3;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // No coverage: line above the sprite.
        set_spr(50, 10, 1'b1);
        start_line(5);
        sweep(0, 80);

        // Row 2 rendered at x=200.
        set_spr(200, 100, 1'b1);
        start_line(102);
        chk("t2_rom_addr", 32'(rom_addr), 32'(2 / S));
        sweep(190, 240);

        // Bottom-edge truncation, then no wrap onto the top lines.
        for (int y = 1020; y <= 1023; y++) begin
            set_spr(100, 1020, 1'b1);
            start_line(YW'(y));
            sweep(90, 140);
        end
        for (int y = 0; y < 12; y++) begin
            set_spr(100, 1020, 1'b1);
            start_line(YW'(y));
            chk("t3_busy", 32'(busy), 32'(0));
            sweep(95, 120);
        end

        // Abort mid-SHIFT at x=207 with a fresh line_start.
        set_spr(200, 100, 1'b1);
        start_line(101);
        sweep(195, 206);
        set_spr(210, 100, 1'b1);
        vga_y = 103;
        step(1'b1, 1'b1, XW'(207));
        chk("t4_pix_on", 32'(pix_on), 32'(0));
        sweep(208, 250);

        // Asynchronous reset while shifting.
        set_spr(200, 100, 1'b1);
        start_line(101);
        sweep(195, 205);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs("t5_async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        set_spr(200, 100, 1'b1);
        start_line(101);
        sweep(190, 240);

        // Scaled-row selection near the top.
        set_spr(30, 0, 1'b1);
        start_line(5);
        chk("t6_rom_addr", 32'(rom_addr), 32'(5 / S));
        sweep(20, 80);

        // Random lines, including off-screen X and disabled sprites.
        for (int n = 0; n < 60; n++) begin
            set_spr($urandom_range(0, 320), int'($urandom_range(0, 1023)),
                    $urandom_range(0, 7) != 0);
            start_line(YW'(int'(spr_y) + int'($urandom_range(0, 44)) - 4));
            x0 = $urandom_range(0, 60);
            sweep(x0, x0 + $urandom_range(150, 290));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
